// File: rtl/swipt_ctrl_pkg.sv
// Shared state encoding, widths and default timing constants for the
// frequency sweep controller.
package swipt_ctrl_pkg;

    localparam int TMR_W  = 20;
    localparam int FREQ_W = 16;
    localparam int CURR_W = 12;

    localparam logic [FREQ_W-1:0] DEF_F_MIN         = 16'd100;
    localparam logic [FREQ_W-1:0] DEF_F_MAX         = 16'd200;
    localparam logic [FREQ_W-1:0] DEF_F_STEP        = 16'd10;
    localparam logic [TMR_W-1:0]  DEF_SETTLE_CYCLES = 20'd1000;
    localparam logic [TMR_W-1:0]  DEF_MEAS_CYCLES   = 20'h9C40;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_STEP    = 3'd4,
        ST_FINISH  = 3'd5
    } sweep_state_e;

    // One extra bit so a step past 16'hFFFF is seen as out of range, not a wrap.
    function automatic logic [FREQ_W:0] freq_add(input logic [FREQ_W-1:0] f,
                                                 input logic [FREQ_W-1:0] s);
        return {1'b0, f} + {1'b0, s};
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; expire pulses on the last counted cycle.
module cycle_timer
    import swipt_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             nrst,
    input  logic             load,
    input  logic             clear,
    input  logic [TMR_W-1:0] load_val,
    output logic             expire
);

    logic [TMR_W-1:0] cnt;

    // A zero load still yields a single-cycle wait so the FSM cannot stall.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (load_val == '0) ? TMR_W'(1) : load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = (cnt == TMR_W'(1));

endmodule

// File: rtl/freq_sweep_ctrl.sv
// Steps the power-stage frequency from F_MIN to F_MAX, measures the mean
// current at each point and parks on the code that gave the highest current.
//
//   state   | meaning
//   IDLE    | waiting for start with link alive
//   SETTLE  | frequency just changed, waiting SETTLE_CYCLES
//   MEASURE | measure window open for MEAS_CYCLES
//   CAPTURE | compare mean_curr against best so far
//   STEP    | advance frequency or decide the sweep is over
//   FINISH  | drive best_freq, pulse done
module freq_sweep_ctrl
    import swipt_ctrl_pkg::*;
#(
    parameter logic [FREQ_W-1:0] F_MIN         = DEF_F_MIN,
    parameter logic [FREQ_W-1:0] F_MAX         = DEF_F_MAX,
    parameter logic [FREQ_W-1:0] F_STEP        = DEF_F_STEP,
    parameter logic [TMR_W-1:0]  SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter logic [TMR_W-1:0]  MEAS_CYCLES   = DEF_MEAS_CYCLES
)(
    input  logic              clk,
    input  logic              nrst,
    input  logic              swiptAlive,
    input  logic              start,
    input  logic [CURR_W-1:0] mean_curr,
    output logic              measure,
    output logic [FREQ_W-1:0] freq,
    output logic [FREQ_W-1:0] best_freq,
    output logic [CURR_W-1:0] best_curr,
    output logic              busy,
    output logic              done
);

    sweep_state_e     state, next_state;
    logic             tmr_load, tmr_clear, tmr_expire;
    logic [TMR_W-1:0] tmr_val;
    logic [FREQ_W:0]  freq_next;
    logic             last_point;
    logic             abort;

    assign freq_next  = freq_add(freq, F_STEP);
    assign last_point = (freq_next > {1'b0, F_MAX});
    assign abort      = (state != ST_IDLE) && !swiptAlive;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (start && swiptAlive) next_state = ST_SETTLE;
                ST_SETTLE:  if (tmr_expire) next_state = ST_MEASURE;
                ST_MEASURE: if (tmr_expire) next_state = ST_CAPTURE;
                ST_CAPTURE: next_state = ST_STEP;
                ST_STEP:    next_state = last_point ? ST_FINISH : ST_SETTLE;
                ST_FINISH:  next_state = ST_IDLE;
                default:    next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        tmr_clear = abort;
        tmr_load  = ((next_state == ST_SETTLE)  && (state != ST_SETTLE)) ||
                    ((next_state == ST_MEASURE) && (state != ST_MEASURE));
        tmr_val   = (next_state == ST_MEASURE) ? MEAS_CYCLES : SETTLE_CYCLES;
    end

    cycle_timer u_timer (
        .clk      (clk),
        .nrst     (nrst),
        .load     (tmr_load),
        .clear    (tmr_clear),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    // Flags are registered from next_state so they line up exactly with state.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            measure <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            measure <= (next_state == ST_MEASURE);
            busy    <= (next_state != ST_IDLE);
            done    <= (next_state == ST_FINISH);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            freq      <= F_MIN;
            best_freq <= F_MIN;
            best_curr <= '0;
        end else if (swiptAlive) begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        freq      <= F_MIN;
                        best_freq <= F_MIN;
                        best_curr <= '0;
                    end
                end
                ST_CAPTURE: begin
                    if (mean_curr > best_curr) begin
                        best_curr <= mean_curr;
                        best_freq <= freq;
                    end
                end
                ST_STEP: begin
                    if (last_point) begin
                        freq <= best_freq;
                    end else begin
                        freq <= freq_next[FREQ_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Directed bench for freq_sweep_ctrl: a small-parameter instance for the
// main scenarios and a near-full-scale instance for the no-wrap case.
module tb_freq_sweep_ctrl;

    logic        clk = 1'b0;
    logic        nrst;
    logic        swiptAlive;
    logic        start;
    logic [11:0] mean_curr;

    logic        meas1, busy1, done1;
    logic [15:0] freq1, bfreq1;
    logic [11:0] bcurr1;
    logic        meas6, busy6, done6;
    logic [15:0] freq6, bfreq6;
    logic [11:0] bcurr6;

    always #5 clk = ~clk;

    freq_sweep_ctrl #(
        .F_MIN(16'd100), .F_MAX(16'd120), .F_STEP(16'd10),
        .SETTLE_CYCLES(20'd4), .MEAS_CYCLES(20'd8)
    ) u1 (
        .clk(clk), .nrst(nrst), .swiptAlive(swiptAlive), .start(start),
        .mean_curr(mean_curr), .measure(meas1), .freq(freq1),
        .best_freq(bfreq1), .best_curr(bcurr1), .busy(busy1), .done(done1)
    );

    freq_sweep_ctrl #(
        .F_MIN(16'hFFF0), .F_MAX(16'hFFFF), .F_STEP(16'h8000),
        .SETTLE_CYCLES(20'd4), .MEAS_CYCLES(20'd8)
    ) u6 (
        .clk(clk), .nrst(nrst), .swiptAlive(swiptAlive), .start(start),
        .mean_curr(mean_curr), .measure(meas6), .freq(freq6),
        .best_freq(bfreq6), .best_curr(bcurr6), .busy(busy6), .done(done6)
    );

    logic        sel;
    logic        o_meas, o_busy, o_done;
    assign o_meas = sel ? meas6 : meas1;
    assign o_busy = sel ? busy6 : busy1;
    assign o_done = sel ? done6 : done1;

    int checks = 0;
    int errors = 0;
    int tbl [3];
    int n_win, bad_len, n_done, cyc, len, timed_out, stopped;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulses start, then follows the selected DUT one cycle at a time until it
    // drops busy, optionally re-pulsing start or stopping inside a window.
    task automatic run_sweep(input logic s, input bit re_start,
                             input int stop_win, input int stop_len);
        logic prev;
        sel = s;
        n_win = 0; bad_len = 0; n_done = 0; cyc = 0; len = 0;
        timed_out = 1; stopped = 0; prev = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (!o_busy) begin
                timed_out = 0;
                break;
            end
            cyc++;
            start = re_start && (cyc == 10 || cyc == 25);
            if (o_meas) begin
                if (!prev) begin
                    n_win++;
                    len = 0;
                    if (n_win <= 3) mean_curr = 12'(tbl[n_win-1]);
                end
                len++;
            end else if (prev && len != 8) begin
                bad_len++;
            end
            if (o_done) n_done++;
            prev = o_meas;
            if (stop_win != 0 && n_win == stop_win && len == stop_len) begin
                stopped = 1;
                timed_out = 0;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        nrst = 1'b0; swiptAlive = 1'b1; start = 1'b0; mean_curr = '0; sel = 1'b0;
        #23;
        chk("rst_freq",   32'(freq1),  100);
        chk("rst_bfreq",  32'(bfreq1), 100);
        chk("rst_bcurr",  32'(bcurr1), 0);
        chk("rst_busy",   32'(busy1),  0);
        chk("rst_meas",   32'(meas1),  0);
        chk("rst_done",   32'(done1),  0);
        chk("rst_freq6",  32'(freq6),  32'hFFF0);
        @(negedge clk) nrst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy",  32'(busy1),  0);

        // Scenario 1: peak at the middle point
        tbl[0] = 50; tbl[1] = 80; tbl[2] = 60;
        run_sweep(1'b0, 1'b0, 0, 0);
        chk("s1_timeout", 32'(timed_out), 0);
        chk("s1_windows", 32'(n_win),    3);
        chk("s1_badlen",  32'(bad_len),  0);
        chk("s1_done",    32'(n_done),   1);
        chk("s1_cycles",  32'(cyc),      43);
        chk("s1_bfreq",   32'(bfreq1),   110);
        chk("s1_bcurr",   32'(bcurr1),   80);
        chk("s1_freq",    32'(freq1),    110);
        chk("s1_done_lo", 32'(done1),    0);
        repeat (20) @(negedge clk);

        // Scenario 2: ties keep the first point
        tbl[0] = 70; tbl[1] = 70; tbl[2] = 70;
        run_sweep(1'b0, 1'b0, 0, 0);
        chk("s2_windows", 32'(n_win),  3);
        chk("s2_bfreq",   32'(bfreq1), 100);
        chk("s2_bcurr",   32'(bcurr1), 70);
        chk("s2_freq",    32'(freq1),  100);
        repeat (20) @(negedge clk);

        // Scenario 3: link lost in the second measure window
        tbl[0] = 50; tbl[1] = 80; tbl[2] = 60;
        run_sweep(1'b0, 1'b0, 2, 3);
        chk("s3_reached", 32'(stopped), 1);
        swiptAlive = 1'b0;
        @(negedge clk);
        chk("s3_meas",    32'(meas1),  0);
        chk("s3_busy",    32'(busy1),  0);
        chk("s3_done",    32'(done1),  0);
        chk("s3_freq",    32'(freq1),  110);
        chk("s3_bcurr",   32'(bcurr1), 50);
        chk("s3_bfreq",   32'(bfreq1), 100);
        swiptAlive = 1'b1;
        n_done = 0; cyc = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy1 || meas1) cyc++;
            if (done1) n_done++;
        end
        chk("s3_no_resume", 32'(cyc),    0);
        chk("s3_no_done",   32'(n_done), 0);

        // Scenario 4: reset during the second settle
        run_sweep(1'b0, 1'b0, 1, 8);
        repeat (3) @(negedge clk);
        chk("s4_pre_freq",  32'(freq1),  110);
        chk("s4_pre_bcurr", 32'(bcurr1), 50);
        #2 nrst = 1'b0;
        #1;
        chk("s4_freq",  32'(freq1),  100);
        chk("s4_bcurr", 32'(bcurr1), 0);
        chk("s4_busy",  32'(busy1),  0);
        chk("s4_meas",  32'(meas1),  0);
        @(negedge clk) nrst = 1'b1;
        cyc = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy1 || meas1) cyc++;
        end
        chk("s4_no_resume", 32'(cyc), 0);

        // Scenario 5: start re-pulsed mid-sweep must change nothing
        run_sweep(1'b0, 1'b1, 0, 0);
        chk("s5_windows", 32'(n_win),  3);
        chk("s5_badlen",  32'(bad_len), 0);
        chk("s5_done",    32'(n_done), 1);
        chk("s5_cycles",  32'(cyc),    43);
        chk("s5_bfreq",   32'(bfreq1), 110);
        chk("s5_bcurr",   32'(bcurr1), 80);
        chk("s5_freq",    32'(freq1),  110);
        repeat (20) @(negedge clk);

        // Scenario 6: step overflows 16 bits -> single point, no wrap
        run_sweep(1'b1, 1'b0, 0, 0);
        chk("s6_timeout", 32'(timed_out), 0);
        chk("s6_windows", 32'(n_win),  1);
        chk("s6_done",    32'(n_done), 1);
        chk("s6_cycles",  32'(cyc),    15);
        chk("s6_bfreq",   32'(bfreq6), 32'hFFF0);
        chk("s6_bcurr",   32'(bcurr6), 50);
        chk("s6_freq",    32'(freq6),  32'hFFF0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/freq_sweep_ctrl.md
FREQ_SWEEP_CTRL -- requirements
Module: freq_sweep_ctrl

Interface
REQ-001 SHALL have parameter F_MIN, default 16'd100: first frequency code of the sweep.
REQ-002 SHALL have parameter F_MAX, default 16'd200: last allowed frequency code.
REQ-003 SHALL have parameter F_STEP, default 16'd10: frequency code increment, nonzero.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 20'd1000: wait after each frequency change before measuring.
REQ-005 SHALL have parameter MEAS_CYCLES, default 20'h9C40: length of the measure window in clocks.
REQ-006 SHALL have port clk, input, 1: single clock, all logic on posedge.
REQ-007 SHALL have port nrst, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port swiptAlive, input, 1: link-alive qualifier; low aborts any sweep.
REQ-009 SHALL have port start, input, 1: single-cycle sweep request.
REQ-010 SHALL have port mean_curr, input, 12: mean current result from the measurement block.
REQ-011 SHALL have port measure, output, 1: measure-window enable to the measurement block.
REQ-012 SHALL have port freq, output, 16: frequency code driven to the power stage.
REQ-013 SHALL have port best_freq, output, 16: frequency code with the highest captured current.
REQ-014 SHALL have port best_curr, output, 12: highest captured mean current.
REQ-015 SHALL have port busy, output, 1: high while a sweep is in progress.
REQ-016 SHALL have port done, output, 1: one-cycle pulse on sweep completion.

Function
REQ-017 SHALL implement states IDLE, SETTLE, MEASURE, CAPTURE, STEP, FINISH.
REQ-018 IDLE with start=1 and swiptAlive=1 SHALL load freq=F_MIN, clear best_curr to 0, set best_freq=F_MIN, load settle counter, and go to SETTLE.
REQ-019 SETTLE SHALL count exactly SETTLE_CYCLES clocks, then go to MEASURE.
REQ-020 MEASURE SHALL hold measure=1 for exactly MEAS_CYCLES consecutive clocks, then go to CAPTURE.
REQ-021 CAPTURE SHALL have measure=0 and sample mean_curr; best_curr and best_freq SHALL update only if mean_curr > best_curr (strict), so on ties the lowest frequency wins.
REQ-022 STEP SHALL compute freq+F_STEP in 17 bits; if the result is greater than F_MAX, go to FINISH, otherwise load freq with it, reload the settle counter, and go to SETTLE.
REQ-023 FINISH SHALL set freq=best_freq, pulse done for one clock, and return to IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 start while busy=1 SHALL be ignored.
REQ-026 swiptAlive=0 in any non-IDLE state SHALL force IDLE on the next clock with measure=0 and no done pulse; best_freq and best_curr hold their values and freq holds its value.
REQ-027 start with swiptAlive=0 SHALL be ignored.
REQ-028 measure SHALL be a registered output; it SHALL never be high outside MEASURE.
REQ-029 If F_MIN > F_MAX, the sweep SHALL perform exactly one point at F_MIN and then finish.

Reset
REQ-030 nrst=0 SHALL asynchronously force state IDLE, measure=0, busy=0, done=0, freq=F_MIN, best_freq=F_MIN, best_curr=0, and all counters to 0.
REQ-031 Reset deasserted mid-sweep SHALL NOT resume the sweep; start is required again.

Structure
REQ-032 State encoding and default timing constants SHALL live in a shared package, swipt_ctrl_pkg.
REQ-033 The settle and measure counting SHALL be one reusable sub-module, cycle_timer (load, count-down, expire pulse), used for both waits.

Verification
REQ-034 Scenario 1: F_MIN=100, F_MAX=120, F_STEP=10, SETTLE=4, MEAS=8; mean_curr=50/80/60 per point -> exactly 3 measure windows of 8 cycles each, best_freq=110, best_curr=80, freq=110 after done.
REQ-035 Scenario 2: equal mean_curr=70 at every point -> best_freq=100 (tie keeps the first point).
REQ-036 Scenario 3: swiptAlive dropped during the second MEASURE -> next clock IDLE, measure=0, busy=0, no done pulse.
REQ-037 Scenario 4: nrst asserted mid-SETTLE -> immediately (asynchronously) freq=100, best_curr=0, busy=0; no activity until a new start.
REQ-038 Scenario 5: start pulsed again while busy -> sweep length and results are identical to Scenario 1.
REQ-039 Scenario 6: F_MAX=16'hFFFF, F_STEP=16'h8000, F_MIN=16'hFFF0 -> single point, no wrap-around, done after one measurement.
